// File: rtl/uart2wb_burst.sv
// rtl/uart2wb_burst.sv - ASCII hex UART command decoder driving Wishbone single/burst cycles
// Build option: define UART2WB_ECHO_EN to echo every accepted command byte on TX before acting on it.
// Ports:
//   i_wb_clk, i_wb_rst              clock, synchronous active-high reset
//   i_wb_ack/err/dat, o_wb_*        Wishbone master (cyc, stb, we, addr, dat, sel)
//   i_uart_rx_dat, i_uart_received_strobe   received byte and its 1-cycle valid pulse
//   o_uart_tx_dat, o_uart_tx_trigger         byte to send and 1-cycle send pulse
//   i_uart_tx_ready_to_send         transmitter can accept a byte
//   o_reset                         1-cycle system reset request ('.')
//   o_busy                          command in progress; rx bytes are dropped
module uart2wb_burst #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic            i_wb_clk,
   input  logic            i_wb_rst,
   input  logic            i_wb_ack,
   input  logic            i_wb_err,
   input  logic [DW-1:0]   i_wb_dat,
   output logic [DW-1:0]   o_wb_dat,
   output logic [AW-1:0]   o_wb_addr,
   output logic [DW/8-1:0] o_wb_sel,
   output logic            o_wb_cyc,
   output logic            o_wb_stb,
   output logic            o_wb_we,
   input  logic [7:0]      i_uart_rx_dat,
   input  logic            i_uart_received_strobe,
   output logic [7:0]      o_uart_tx_dat,
   output logic            o_uart_tx_trigger,
   input  logic            i_uart_tx_ready_to_send,
   output logic            o_reset,
   output logic            o_busy
);
   localparam int SW = DW / 8;
   localparam int NW = DW / 4;
   localparam logic [7:0] LF = 8'h0A;
`ifdef UART2WB_ECHO_EN
   localparam logic ECHO_EN = 1'b1;
`else
   localparam logic ECHO_EN = 1'b0;
`endif

   typedef enum logic [2:0] {IDLE, WB_REQ, TX_WORD, TX_STAT, NEXT} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   data_q, data_d;
   logic [SW-1:0]   sel_q, sel_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [8:0]      rem_q, rem_d;
   logic [1:0]      tsel_q, tsel_d;     // target of hex digits: 0 addr, 1 data, 2 sel, 3 count
   logic            we_q, we_d;
   logic [15:0]     tmo_q, tmo_d;
   logic [4:0]      idx_q, idx_d;       // character index within the current TX message
   logic            trig_q, trig_d;
   logic            rst_req_q, rst_req_d;
   logic [7:0]      rx_q, rx_d;
   logic            rx_vld_q, rx_vld_d;
   logic [7:0]      stat_q, stat_d;     // first char of a TX_STAT message
   logic            echo_q, echo_d;     // TX_STAT is sending an echo (single char, no LF)
   logic            echoed_q, echoed_d; // pending rx byte has already been echoed

   logic [7:0]      tx_char;
   logic            tx_last;
   logic [3:0]      nib;
   logic [4:0]      hx;

   function automatic logic [4:0] hex_decode(input logic [7:0] c);
      if (c >= "0" && c <= "9") return {1'b1, 4'(c - 8'h30)};
      if (c >= "A" && c <= "F") return {1'b1, 4'(c - 8'h37)};
      return 5'd0;
   endfunction

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? 8'(n) + 8'h30 : 8'(n) + 8'h37;
   endfunction

   // Current TX character is a pure function of state/index, so it is stable
   // the cycle before the trigger and stays put until the index advances.
   always_comb begin
      tx_char = 8'h00;
      tx_last = 1'b0;
      nib     = 4'h0;
      if (state_q == TX_WORD) begin
         if (idx_q < 5'(NW)) begin
            nib     = 4'(data_q >> (4 * (NW - 1 - int'(idx_q))));
            tx_char = hex_char(nib);
         end else begin
            tx_char = LF;
            tx_last = 1'b1;
         end
      end else if (state_q == TX_STAT) begin
         tx_char = (idx_q == 5'd0) ? stat_q : LF;
         tx_last = echo_q || (idx_q != 5'd0);
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      data_d    = data_q;
      sel_d     = sel_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      tsel_d    = tsel_q;
      we_d      = we_q;
      tmo_d     = tmo_q;
      idx_d     = idx_q;
      trig_d    = 1'b0;
      rst_req_d = 1'b0;
      rx_d      = rx_q;
      rx_vld_d  = rx_vld_q;
      stat_d    = stat_q;
      echo_d    = echo_q;
      echoed_d  = echoed_q;
      hx        = hex_decode(rx_q);

      case (state_q)
         IDLE: begin
            if (rx_vld_q) begin
               if (ECHO_EN && !echoed_q) begin
                  stat_d  = rx_q;
                  echo_d  = 1'b1;
                  idx_d   = 5'd0;
                  state_d = TX_STAT;
               end else begin
                  rx_vld_d = 1'b0;
                  echoed_d = 1'b0;
                  case (rx_q)
                     "a": begin tsel_d = 2'd0; addr_d = '0; end
                     "d": begin tsel_d = 2'd1; data_d = '0; end
                     "s": begin tsel_d = 2'd2; sel_d  = '0; end
                     "n": begin tsel_d = 2'd3; cnt_d  = '0; end
                     "r", "w": begin
                        we_d    = (rx_q == "w");
                        rem_d   = (cnt_q == 8'd0) ? 9'd1 : {1'b0, cnt_q};
                        tmo_d   = 16'd0;
                        state_d = WB_REQ;
                     end
                     ".": begin
                        addr_d    = '0;
                        data_d    = '0;
                        sel_d     = '1;
                        cnt_d     = '0;
                        rem_d     = '0;
                        tsel_d    = '0;
                        we_d      = 1'b0;
                        tmo_d     = '0;
                        idx_d     = '0;
                        stat_d    = '0;
                        echo_d    = 1'b0;
                        rst_req_d = 1'b1;
                     end
                     default: begin
                        if (hx[4]) begin
                           case (tsel_q)
                              2'd0:    addr_d = AW'({addr_q, hx[3:0]});
                              2'd1:    data_d = DW'({data_q, hx[3:0]});
                              2'd2:    sel_d  = SW'({sel_q, hx[3:0]});
                              default: cnt_d  = {cnt_q[3:0], hx[3:0]};
                           endcase
                        end else begin
                           stat_d  = "?";
                           echo_d  = 1'b0;
                           idx_d   = 5'd0;
                           state_d = TX_STAT;
                        end
                     end
                  endcase
               end
            end
         end
         WB_REQ: begin
            // err has priority over ack; timeout counts cycles spent waiting
            if (i_wb_err || (!i_wb_ack && tmo_q == 16'(TIMEOUT - 1))) begin
               stat_d  = "!";
               echo_d  = 1'b0;
               idx_d   = 5'd0;
               state_d = TX_STAT;
            end else if (i_wb_ack) begin
               if (we_q) begin
                  state_d = NEXT;
               end else begin
                  data_d  = i_wb_dat;
                  idx_d   = 5'd0;
                  state_d = TX_WORD;
               end
            end else begin
               tmo_d = tmo_q + 16'd1;
            end
         end
         TX_WORD, TX_STAT: begin
            if (trig_q) begin
               if (tx_last) begin
                  idx_d = 5'd0;
                  if (state_q == TX_WORD) begin
                     state_d = NEXT;
                  end else begin
                     echoed_d = echo_q;
                     echo_d   = 1'b0;
                     state_d  = IDLE;
                  end
               end else begin
                  idx_d = idx_q + 5'd1;
               end
            end else if (i_uart_tx_ready_to_send) begin
               trig_d = 1'b1;
            end
         end
         NEXT: begin
            addr_d = addr_q + AW'(1);
            rem_d  = rem_q - 9'd1;
            if (rem_q > 9'd1) begin
               tmo_d   = 16'd0;
               state_d = WB_REQ;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Capture only while idle and the holding slot is free after this cycle
      if (state_q == IDLE && !rx_vld_d && i_uart_received_strobe) begin
         rx_d     = i_uart_rx_dat;
         rx_vld_d = 1'b1;
      end
   end

   always_ff @(posedge i_wb_clk) begin
      if (i_wb_rst) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         data_q    <= '0;
         sel_q     <= '1;
         cnt_q     <= '0;
         rem_q     <= '0;
         tsel_q    <= '0;
         we_q      <= 1'b0;
         tmo_q     <= '0;
         idx_q     <= '0;
         trig_q    <= 1'b0;
         rst_req_q <= 1'b0;
         rx_q      <= '0;
         rx_vld_q  <= 1'b0;
         stat_q    <= '0;
         echo_q    <= 1'b0;
         echoed_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         sel_q     <= sel_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         tsel_q    <= tsel_d;
         we_q      <= we_d;
         tmo_q     <= tmo_d;
         idx_q     <= idx_d;
         trig_q    <= trig_d;
         rst_req_q <= rst_req_d;
         rx_q      <= rx_d;
         rx_vld_q  <= rx_vld_d;
         stat_q    <= stat_d;
         echo_q    <= echo_d;
         echoed_q  <= echoed_d;
      end
   end

   assign o_wb_dat          = data_q;
   assign o_wb_addr         = addr_q;
   assign o_wb_sel          = sel_q;
   assign o_wb_cyc          = (state_q == WB_REQ);
   assign o_wb_stb          = (state_q == WB_REQ);
   assign o_wb_we           = (state_q == WB_REQ) && we_q;
   assign o_uart_tx_dat     = tx_char;
   assign o_uart_tx_trigger = trig_q;
   assign o_reset           = rst_req_q;
   assign o_busy            = (state_q != IDLE);
endmodule

// File: tb/tb_uart2wb_burst.sv
// tb/tb_uart2wb_burst.sv - scoreboard bench for uart2wb_burst
module tb_uart2wb_burst;
   localparam int TO = 20;

   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
   } bus_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_ack, wb_err;
   logic [31:0] wb_dat_i, wb_dat_o, wb_addr;
   logic [3:0]  wb_sel;
   logic        cyc, stb, we;
   logic [7:0]  rx_dat, tx_dat;
   logic        rx_stb, tx_trig, tx_rdy, sys_rst, busy;

   int checks = 0;
   int errors = 0;
   int mode = 0;          // slave: 0 ack, 1 never respond, 2 err on beat err_beat
   int err_beat = 0;
   int sbeat = 0;
   int trig_cnt = 0;
   int rst_cnt = 0;
   logic [31:0] mem [logic [31:0]];
   logic [7:0]  tx_q[$];
   bus_t        bus_q[$];

   always #5 clk = ~clk;

   uart2wb_burst #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
      .i_wb_clk(clk), .i_wb_rst(rst), .i_wb_ack(wb_ack), .i_wb_err(wb_err),
      .i_wb_dat(wb_dat_i), .o_wb_dat(wb_dat_o), .o_wb_addr(wb_addr), .o_wb_sel(wb_sel),
      .o_wb_cyc(cyc), .o_wb_stb(stb), .o_wb_we(we),
      .i_uart_rx_dat(rx_dat), .i_uart_received_strobe(rx_stb),
      .o_uart_tx_dat(tx_dat), .o_uart_tx_trigger(tx_trig),
      .i_uart_tx_ready_to_send(tx_rdy), .o_reset(sys_rst), .o_busy(busy)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      int quiet = 0;
      while (quiet < 2) begin
         @(negedge clk);
         if (busy) quiet = 0; else quiet++;
         n++;
         if (n > 5000) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy=%0b after %0d cycles, required 0", busy, n);
            return;
         end
      end
   endtask

   task automatic send_byte(input byte b);
      wait_idle();
`ifdef UART2WB_ECHO_EN
      tx_q.push_back(b);
`endif
      @(posedge clk); #2;
      rx_dat = b;
      rx_stb = 1'b1;
      @(posedge clk); #2;
      rx_stb = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic exp_str(input string s);
      for (int i = 0; i < s.len(); i++) tx_q.push_back(s[i]);
   endtask

   task automatic exp_bus(input logic w, input logic [31:0] a, input logic [31:0] d);
      bus_t t;
      t.we = w; t.adr = a; t.dat = d;
      bus_q.push_back(t);
   endtask

   task automatic pop_bus();
      bus_t t;
      if (bus_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL bus_unexpected: got beat we=%0b addr=%0h, required none", we, wb_addr);
      end else begin
         t = bus_q.pop_front();
         chk("bus_we", we, t.we);
         chk("bus_addr", wb_addr, t.adr);
         if (t.we) chk("bus_wdat", wb_dat_o, t.dat);
      end
   endtask

   // Wishbone slave model
   initial begin
      wb_ack = 1'b0; wb_err = 1'b0; wb_dat_i = '0;
      forever begin
         @(posedge clk); #1;
         if (cyc && stb && !wb_ack && !wb_err && mode != 1) begin
            sbeat++;
            if (mode == 2 && sbeat == err_beat) begin
               wb_err = 1'b1;
            end else begin
               wb_ack = 1'b1;
               if (we) mem[wb_addr] = wb_dat_o;
               else wb_dat_i = mem.exists(wb_addr) ? mem[wb_addr] : 32'h0;
            end
         end else begin
            wb_ack = 1'b0;
            wb_err = 1'b0;
         end
      end
   end

   // TX monitor
   initial begin
      logic [7:0] prev_dat = 8'h00;
      logic       prev_rdy = 1'b0;
      forever begin
         @(negedge clk);
         if (sys_rst) rst_cnt++;
         if (tx_trig) begin
            trig_cnt++;
            chk("tx_ready_before_trigger", prev_rdy, 1'b1);
            chk("tx_dat_stable", tx_dat, prev_dat);
            if (tx_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL tx_unexpected: got %0h, required no char", tx_dat);
            end else begin
               chk("tx_char", tx_dat, tx_q.pop_front());
            end
         end
         prev_dat = tx_dat;
         prev_rdy = tx_rdy;
      end
   end

   // Bus monitor
   initial begin
      int   hi_run = 0;
      int   low_run = 0;
      logic resp_seen = 1'b0;
      logic gap_armed = 1'b0;
      logic rst_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (cyc) begin
            if (low_run > 0 && gap_armed) chk("write_beat_gap", low_run, 1);
            gap_armed = 1'b0;
            low_run = 0;
            hi_run++;
            if (wb_ack || wb_err) begin
               resp_seen = 1'b1;
               pop_bus();
               if (wb_ack && we) gap_armed = 1'b1;
            end
         end else begin
            if (hi_run > 0 && !resp_seen && !rst_prev) begin
               chk("timeout_cycles", hi_run, TO);
               pop_bus();
            end
            hi_run = 0;
            resp_seen = 1'b0;
            low_run++;
            if (!busy) gap_armed = 1'b0;
         end
         rst_prev = rst;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   initial begin
      int n;
      int tc;
      rst = 1'b1; rx_dat = 8'h00; rx_stb = 1'b0; tx_rdy = 1'b1;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      chk("rst_cyc", cyc, 0);
      chk("rst_stb", stb, 0);
      chk("rst_we", we, 0);
      chk("rst_sel", wb_sel, 4'hF);
      chk("rst_addr", wb_addr, 0);
      chk("rst_dat", wb_dat_o, 0);
      chk("rst_trig", tx_trig, 0);
      chk("rst_reset", sys_rst, 0);
      chk("rst_busy", busy, 0);

      // single write then read back
      exp_bus(1'b1, 32'h10, 32'h12345678);
      send_str("a10d12345678w");
      exp_bus(1'b0, 32'h10, 32'h0);
      send_str("a10r");
      exp_str("12345678\n");
      wait_idle();

      // 3-beat read burst
      mem[32'h20] = 32'hA; mem[32'h21] = 32'hB; mem[32'h22] = 32'hC;
      exp_bus(1'b0, 32'h20, 0); exp_bus(1'b0, 32'h21, 0); exp_bus(1'b0, 32'h22, 0);
      send_str("a20n03r");
      exp_str("0000000A\n0000000B\n0000000C\n");
      wait_idle();
      chk("burst_end_addr", wb_addr, 32'h23);

      // timeout on unmapped address
      mode = 1;
      exp_bus(1'b0, 32'h40, 0);
      send_str("na40r");
      exp_str("!\n");
      wait_idle();
      chk("timeout_addr", wb_addr, 32'h40);

      // write burst aborted by err on beat 2
      mode = 2; err_beat = 2; sbeat = 0;
      exp_bus(1'b1, 32'h30, 32'h0000BEEF); exp_bus(1'b1, 32'h31, 32'h0000BEEF);
      send_str("a30d0000BEEFn04w");
      exp_str("!\n");
      wait_idle();
      chk("err_addr", wb_addr, 32'h31);
      mode = 0;

      // invalid command
      send_str("x");
      exp_str("?\n");
      wait_idle();

      // sel load then '.' reset request
      send_str("s3a55");
      wait_idle();
      chk("sel_loaded", wb_sel, 4'h3);
      rst_cnt = 0;
      send_str(".");
      wait_idle();
      chk("reset_pulse_cycles", rst_cnt, 1);
      chk("dot_addr", wb_addr, 0);
      chk("dot_sel", wb_sel, 4'hF);
      chk("dot_dat", wb_dat_o, 0);

      // TX back-pressure during read response
      send_str("a10");
      exp_bus(1'b0, 32'h10, 0);
      tx_rdy = 1'b0;
      send_str("r");
      tc = trig_cnt;
      repeat (50) @(posedge clk);
      @(negedge clk);
      chk("no_trig_while_not_ready", trig_cnt, tc);
      chk("busy_while_blocked", busy, 1);
      @(posedge clk); #2 tx_rdy = 1'b1;
      exp_str("12345678\n");
      wait_idle();

      // reset in the middle of a bus cycle
      mode = 1;
      send_str("a40r");
      n = 0;
      while (!cyc && n < 100) begin @(negedge clk); n++; end
      chk("rst_mid_cyc_seen", cyc, 1);
      repeat (5) @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk); #2 rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_cyc", cyc, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_trig", tx_trig, 0);
      mode = 0;

      repeat (10) @(negedge clk);
      chk("tx_queue_empty", tx_q.size(), 0);
      chk("bus_queue_empty", bus_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
